reshaper_job_sched: RTL

// - Job scheduler in front of the reshaper. Accepts job descriptors from NREQ requesters,

---
 rtl/reshaper_job_sched_if.sv | 33 +++
 rtl/reshaper_job_sched.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reshaper_job_sched_if.sv
// Bundle between the reshaper job scheduler (master) and its requesters/reshaper (slave).
interface reshaper_job_sched_if #(
   parameter int unsigned AW     = 16,
   parameter int unsigned ADIM   = 6,
   parameter int unsigned NREQ   = 4,
   parameter int unsigned QDEPTH = 4
);
   localparam int unsigned DESC_W = AW * (6 + 4 * ADIM);
   localparam int unsigned IDW    = $clog2(NREQ);
   localparam int unsigned LVW    = $clog2(QDEPTH) + 1;

   logic [NREQ-1:0]        req_vld;
   logic [NREQ*DESC_W-1:0] req_desc;
   logic [NREQ-1:0]        req_rdy;
   logic [DESC_W-1:0]      cfg_desc;
   logic                   init_pulse;
   logic                   finish;
   logic                   done_vld;
   logic [IDW-1:0]         done_id;
   logic [1:0]             done_code;
   logic                   busy;
   logic [LVW-1:0]         q_level;

   modport master (
      input  req_vld, req_desc, finish,
      output req_rdy, cfg_desc, init_pulse, done_vld, done_id, done_code, busy, q_level
   );

   modport slave (
      output req_vld, req_desc, finish,
      input  req_rdy, cfg_desc, init_pulse, done_vld, done_id, done_code, busy, q_level
   );
endinterface

// File: rtl/reshaper_job_sched.sv
// Round-robin job scheduler feeding the reshaper: FIFO of descriptors, config/start/finish FSM.
// Optional RUN watchdog enabled by defining RSHP_WDOG_EN.
module reshaper_job_sched #(
   parameter int unsigned AW     = 16,
   parameter int unsigned ADIM   = 6,
   parameter int unsigned NREQ   = 4,
   parameter int unsigned QDEPTH = 4,
   parameter int unsigned TMO_W  = 20
) (
   input logic                  clk,
   input logic                  reset,
   reshaper_job_sched_if.master bus
);
   localparam int unsigned DESC_W = AW * (6 + 4 * ADIM);
   localparam int unsigned IDW    = $clog2(NREQ);
   localparam int unsigned PW     = $clog2(QDEPTH);
   localparam int unsigned LVW    = PW + 1;
   localparam int unsigned EW     = IDW + DESC_W;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StStart = 3'd2;
   localparam logic [2:0] StRun   = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;

   localparam logic [1:0] CodeOk      = 2'd0;
   localparam logic [1:0] CodeZero    = 2'd1;
   localparam logic [1:0] CodeTimeout = 2'd2;

   logic [EW-1:0]     mem_q [QDEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LVW-1:0]    level_q;
   logic [IDW-1:0]    rr_q;
   logic [IDW-1:0]    grant_idx;
   logic [NREQ-1:0]   grant_oh;
   logic [NREQ-1:0]   rdy;
   logic              full, empty, push, pop;
   logic [EW-1:0]     push_entry;

   logic [2:0]        state_q, state_d;
   logic [DESC_W-1:0] cfg_q;
   logic [IDW-1:0]    id_q;
   logic [1:0]        code_q, code_d;
   logic [AW-1:0]     rreq_num, wreq_num;

   assign full  = (level_q == LVW'(QDEPTH));
   assign empty = (level_q == '0);

   // First valid requester at or after the round-robin pointer.
   always_comb begin
      int unsigned idx;
      logic found;
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(rr_q) + k) % NREQ;
         if (!found && bus.req_vld[idx]) begin
            found         = 1'b1;
            grant_oh[idx] = 1'b1;
            grant_idx     = IDW'(idx);
         end
      end
   end

   // Full uses the registered level, so a pop in this cycle cannot free a slot yet.
   assign rdy        = (reset || full) ? '0 : grant_oh;
   assign push       = |(bus.req_vld & rdy);
   assign pop        = (state_q == StIdle) && !empty;
   assign push_entry = {grant_idx, bus.req_desc[32'(grant_idx)*DESC_W +: DESC_W]};

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         rr_q     <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            rr_q     <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      level_q <= level_q + 1'b1;
         else if (pop && !push) level_q <= level_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

   assign rreq_num = cfg_q[0 +: AW];
   assign wreq_num = cfg_q[2*AW +: AW];

`ifdef RSHP_WDOG_EN
   localparam logic [TMO_W-1:0] WdogLast = {{(TMO_W-1){1'b1}}, 1'b0};
   logic [TMO_W-1:0] wdog_q, wdog_d;
`endif

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
`ifdef RSHP_WDOG_EN
      wdog_d  = wdog_q;
`endif
      case (state_q)
         StIdle:  if (!empty) state_d = StLoad;
         StLoad: begin
            if (rreq_num == '0 || wreq_num == '0) begin
               state_d = StDone;
               code_d  = CodeZero;
            end else begin
               state_d = StStart;
            end
         end
         StStart: begin
            state_d = StRun;
`ifdef RSHP_WDOG_EN
            wdog_d  = '0;
`endif
         end
         StRun: begin
`ifdef RSHP_WDOG_EN
            wdog_d = wdog_q + 1'b1;
`endif
            if (bus.finish) begin
               state_d = StDone;
               code_d  = CodeOk;
            end
`ifdef RSHP_WDOG_EN
            // Counter would reach all-ones this cycle: finish above still wins.
            else if (wdog_q == WdogLast) begin
               state_d = StDone;
               code_d  = CodeTimeout;
            end
`endif
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cfg_q   <= '0;
         id_q    <= '0;
         code_q  <= CodeOk;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         if (pop) {id_q, cfg_q} <= mem_q[rd_ptr_q];
      end
   end

`ifdef RSHP_WDOG_EN
   always_ff @(posedge clk) begin
      if (reset) wdog_q <= '0;
      else       wdog_q <= wdog_d;
   end
`endif

   assign bus.req_rdy    = rdy;
   assign bus.cfg_desc   = cfg_q;
   assign bus.init_pulse = (state_q == StStart);
   assign bus.done_vld   = (state_q == StDone);
   assign bus.done_id    = (state_q == StDone) ? id_q : '0;
   assign bus.done_code  = (state_q == StDone) ? code_q : CodeOk;
   assign bus.busy       = (state_q != StIdle);
   assign bus.q_level    = level_q;
endmodule
